// File: rtl/pfw_mp_if.sv
// Packet stream bundle for the pfw_mp forwarding stage: ingress words with
// head-word metadata on the in_* side, forwarded words and action on the out_* side.
interface pfw_mp_if #(
    parameter int PORT_NUM = 4
);
    logic [133:0]        in_data;
    logic                in_data_wr;
    logic [2:0]          in_pkttype;
    logic [101:0]        in_key;
    logic [133:0]        out_data;
    logic                out_data_wr;
    logic                out_valid;
    logic                out_valid_wr;
    logic [4+PORT_NUM:0] out_action;
    logic                out_action_wr;

    modport master (
        output in_data, in_data_wr, in_pkttype, in_key,
        input  out_data, out_data_wr, out_valid, out_valid_wr, out_action, out_action_wr
    );

    modport slave (
        input  in_data, in_data_wr, in_pkttype, in_key,
        output out_data, out_data_wr, out_valid, out_valid_wr, out_action, out_action_wr
    );
endinterface

// File: rtl/pfw_mp.sv
// Multi-port forwarding-decision stage: per packet chooses drop/unicast/broadcast,
// emits an egress bitmap with the head word and forwards words at 2-cycle latency.
module pfw_mp #(
    parameter int         PORT_NUM  = 4,
    parameter int         IDX_W     = 4,
    parameter int         HOST_PORT = 0,
    parameter logic [2:0] PTP_TYPE  = 3'h2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pfw_mp_if.slave                   bus,
    input  logic [47:0]               local_mac_addr,
    input  logic [PORT_NUM-1:0]       port_en,
    input  logic [PORT_NUM*IDX_W-1:0] fwd_map,
    input  logic [IDX_W-1:0]          ptp_port,
    output logic [31:0]               fwd_cnt,
    output logic [31:0]               drop_cnt,
    output logic [31:0]               err_cnt
);
    typedef enum logic [1:0] {IDLE_S, FWD_S, DISC_S} state_t;

    localparam logic [1:0]  CTL_HEAD = 2'b01;
    localparam logic [1:0]  CTL_TAIL = 2'b10;
    localparam logic [31:0] HOST_IDX = HOST_PORT;

    function automatic logic [PORT_NUM-1:0] onehot(input logic [31:0] idx);
        logic [PORT_NUM-1:0] oh;
        oh = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) oh[p] = (idx == p);
        return oh;
    endfunction

    state_t state, state_nxt;
    logic   disc, disc_nxt;

    logic [5:0]          ip;
    logic [47:0]         dmac, smac;
    logic                ip_ok, en_ip, ip_host;
    logic [IDX_W-1:0]    map_ip;
    logic [1:0]          dec_mode;
    logic [PORT_NUM-1:0] dec_raw, dec_bmp;
    logic                dec_drop;
    logic [4+PORT_NUM:0] dec_act;

    logic is_head, is_tail;
    logic push, act_load, fwd_inc, drop_inc, err_inc;

    logic [133:0]        s1_data;
    logic                s1_wr, s1_head, s1_tail;
    logic [4+PORT_NUM:0] s1_act;

    assign dmac    = bus.in_key[101:54];
    assign smac    = bus.in_key[53:6];
    assign ip      = bus.in_key[5:0];
    assign ip_host = (32'(ip) == HOST_IDX);
    assign is_head = bus.in_data_wr && (bus.in_data[133:132] == CTL_HEAD);
    assign is_tail = bus.in_data_wr && (bus.in_data[133:132] == CTL_TAIL);

    always_comb begin
        ip_ok    = 1'b0;
        en_ip    = 1'b0;
        map_ip   = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            if (32'(ip) == p) begin
                ip_ok  = 1'b1;
                en_ip  = port_en[p];
                map_ip = fwd_map[p*IDX_W +: IDX_W];
            end
        end
        dec_mode = 2'b00;
        if (dmac == '1) begin
            dec_mode = 2'b10;
            dec_raw  = port_en & ~onehot(32'(ip));
        end else if (dmac == local_mac_addr) begin
            dec_raw  = onehot(HOST_IDX);
        end else if (ip_host && (bus.in_pkttype == PTP_TYPE)) begin
            dec_raw  = onehot(32'(ptp_port));
        end else begin
            dec_raw  = onehot(32'(map_ip));
        end
        dec_bmp  = dec_raw & port_en;
        dec_drop = !ip_ok || !en_ip || ((smac == local_mac_addr) && !ip_host) ||
                   (dec_bmp == '0);
        dec_act  = {dec_mode, bus.in_pkttype, dec_bmp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_S;
            disc  <= 1'b0;
        end else begin
            state <= state_nxt;
            disc  <= disc_nxt;
        end
    end

    // disc marks an errant head inside a forwarded packet: its words are
    // swallowed, but the tail is still passed so the open packet closes.
    always_comb begin
        state_nxt = state;
        disc_nxt  = disc;
        push      = 1'b0;
        act_load  = 1'b0;
        fwd_inc   = 1'b0;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE_S, DISC_S: begin
                if (is_head) begin
                    err_inc = (state == DISC_S);
                    if (dec_drop) begin
                        drop_inc  = 1'b1;
                        state_nxt = DISC_S;
                    end else begin
                        fwd_inc   = 1'b1;
                        push      = 1'b1;
                        act_load  = 1'b1;
                        disc_nxt  = 1'b0;
                        state_nxt = FWD_S;
                    end
                end else if (state == IDLE_S) begin
                    err_inc = bus.in_data_wr;
                end else if (is_tail) begin
                    state_nxt = IDLE_S;
                end
            end
            FWD_S: begin
                if (is_head) begin
                    err_inc  = 1'b1;
                    disc_nxt = 1'b1;
                end else if (is_tail) begin
                    push      = 1'b1;
                    disc_nxt  = 1'b0;
                    state_nxt = IDLE_S;
                end else begin
                    push = bus.in_data_wr && !disc;
                end
            end
            default: state_nxt = IDLE_S;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data           <= '0;
            s1_wr             <= 1'b0;
            s1_head           <= 1'b0;
            s1_tail           <= 1'b0;
            s1_act            <= '0;
            bus.out_data      <= '0;
            bus.out_data_wr   <= 1'b0;
            bus.out_action    <= '0;
            bus.out_action_wr <= 1'b0;
            bus.out_valid     <= 1'b0;
            bus.out_valid_wr  <= 1'b0;
        end else begin
            s1_wr   <= push;
            s1_head <= act_load;
            s1_tail <= push && is_tail;
            if (push)     s1_data <= bus.in_data;
            if (act_load) s1_act  <= dec_act;
            bus.out_data_wr   <= s1_wr;
            bus.out_action_wr <= s1_head;
            bus.out_valid     <= s1_tail;
            bus.out_valid_wr  <= s1_tail;
            if (s1_wr)   bus.out_data   <= s1_data;
            if (s1_head) bus.out_action <= s1_act;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt  <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (fwd_inc)  fwd_cnt  <= fwd_cnt + 32'd1;
            if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
            if (err_inc)  err_cnt  <= err_cnt + 32'd1;
        end
    end
endmodule
